key_debounce: RTL and testbench

Debounces and synchronises one raw, active-low mechanical key input. It produces the stable registered level `key_filter`, plus single-cycle press, release and long-press pulses. It sits directly upstream of the beeper/LED control stages, which toggle on the falling edge of `key_filter`. `key_filter` therefore changes only on clean, debounced transitions and never glitches.

---
 rtl/key_pkg.sv | 25 ++
 rtl/key_sync2.sv | 38 +++
 rtl/key_debounce.sv | 155 +++++++++++++++
 tb/tb_key_debounce.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : key_pkg
//  Description : Shared definitions for the key input path: debounce FSM
//                state encoding and the default 50 MHz timing constants.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package key_pkg;

  // Debounce FSM states. Encoding is fixed so other key-path blocks and
  // debug views can decode a raw state value consistently.
  typedef enum logic [1:0] {
    IDLE         = 2'd0,  // released, stable
    PRESS_WAIT   = 2'd1,  // low seen, qualifying the press
    PRESSED      = 2'd2,  // pressed, stable
    RELEASE_WAIT = 2'd3   // high seen, qualifying the release
  } key_state_e;

  // 20 ms debounce window and 1 s long-press time at a 50 MHz clock.
  localparam int KEY_DEB_CNT_50M  = 1_000_000;
  localparam int KEY_LONG_CNT_50M = 50_000_000;

endpackage
`default_nettype wire

// File: rtl/key_sync2.sv
`default_nettype none
// ============================================================================
//  Module      : key_sync2
//  Description : Two-flop synchroniser for a single asynchronous pin input.
//                Both flops load RST_VAL on reset, so the synchronised
//                output starts at the pin's inactive level.
//  Ports       : sys_clk   - system clock, rising edge
//                sys_rst_n - asynchronous active-low reset
//                d_i       - raw asynchronous input
//                q_o       - synchronised output (two cycles of latency)
//  Revision    : 1.0  initial release
// ============================================================================
module key_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce
//  Description : Debounces one raw active-low key. Produces a glitch-free
//                registered level plus one-cycle press, release and
//                long-press pulses.
//  Parameters  : DEB_CNT  - stable synchronised samples needed to accept a
//                           transition (>= 2)
//                LONG_CNT - cycles key_filter must stay low before key_long
//                           fires (> DEB_CNT)
//  Ports       : sys_clk     - system clock, rising edge
//                sys_rst_n   - asynchronous active-low reset
//                key         - raw key pin, 0 = pressed
//                key_filter  - debounced level, 0 = pressed (registered)
//                key_press   - one-cycle pulse as key_filter falls
//                key_release - one-cycle pulse as key_filter rises
//                key_long    - one-cycle pulse, at most once per press
//  Revision    : 1.0  initial release
// ============================================================================
module key_debounce
  import key_pkg::*;
#(
  parameter int DEB_CNT  = KEY_DEB_CNT_50M,
  parameter int LONG_CNT = KEY_LONG_CNT_50M
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key,
  output logic key_filter,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam int DEB_W  = $clog2(DEB_CNT);
  localparam int LONG_W = $clog2(LONG_CNT + 1);

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CNT - 1);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CNT - 1);
  localparam logic [LONG_W-1:0] LONG_SAT  = LONG_W'(LONG_CNT);

  logic key_s;

  key_sync2 #(
    .RST_VAL (1'b1)
  ) u_sync (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .d_i       (key),
    .q_o       (key_s)
  );

  key_state_e        state_q,    state_d;
  logic [DEB_W-1:0]  deb_cnt_q,  deb_cnt_d;
  logic [LONG_W-1:0] long_cnt_q, long_cnt_d;
  logic              filter_q,   filter_d;
  logic              press_q,    press_d;
  logic              release_q,  release_d;
  logic              long_q,     long_d;
  logic              long_run;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      deb_cnt_q  <= '0;
      long_cnt_q <= '0;
      filter_q   <= 1'b1;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      deb_cnt_q  <= deb_cnt_d;
      long_cnt_q <= long_cnt_d;
      filter_q   <= filter_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
    end
  end

  // Debounce FSM. Any sample opposite to the transition being qualified
  // drops straight back to the stable state, so the window restarts from 0.
  always_comb begin
    state_d   = state_q;
    deb_cnt_d = deb_cnt_q;
    filter_d  = filter_q;
    press_d   = 1'b0;
    release_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (!key_s) begin
          state_d   = PRESS_WAIT;
          deb_cnt_d = '0;
        end
      end
      PRESS_WAIT: begin
        if (key_s) begin
          state_d   = IDLE;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d  = PRESSED;
          filter_d = 1'b0;
          press_d  = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (key_s) begin
          state_d   = RELEASE_WAIT;
          deb_cnt_d = '0;
        end
      end
      RELEASE_WAIT: begin
        if (!key_s) begin
          state_d   = PRESSED;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d   = IDLE;
          filter_d  = 1'b1;
          release_d = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        deb_cnt_d = '0;
      end
    endcase
  end

  // Long-press timer runs for as long as the press is accepted, including
  // while a release is still being qualified, so release bounce does not
  // restart it. Saturating one past the pulse point guarantees a single
  // key_long per press.
  always_comb begin
    long_run   = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
    long_cnt_d = '0;
    long_d     = 1'b0;
    if (long_run) begin
      long_cnt_d = (long_cnt_q == LONG_SAT) ? long_cnt_q : long_cnt_q + 1'b1;
      long_d     = (long_cnt_q == LONG_LAST);
    end
  end

  assign key_filter  = filter_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_long    = long_q;

endmodule
`default_nettype wire

// File: tb/tb_key_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_debounce
//  Description : Self-checking bench for key_debounce with DEB_CNT=8 and
//                LONG_CNT=32. Directed vector table and corner sequences,
//                then randomised key activity compared every cycle with a
//                behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_key_debounce;

  localparam int DEB_CNT  = 8;
  localparam int LONG_CNT = 32;

  logic sys_clk = 1'b0;
  logic sys_rst_n;
  logic key;
  logic key_filter;
  logic key_press;
  logic key_release;
  logic key_long;

  key_debounce #(
    .DEB_CNT  (DEB_CNT),
    .LONG_CNT (LONG_CNT)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .key         (key),
    .key_filter  (key_filter),
    .key_press   (key_press),
    .key_release (key_release),
    .key_long    (key_long)
  );

  always #5 sys_clk = ~sys_clk;

  // --------------------------------------------------------------------------
  // Behavioural model. A transition is accepted once the key, seen through a
  // two-sample delay, has disagreed with the filtered level for DEB_CNT+1
  // consecutive edges. key_long fires on the LONG_CNT-th edge after the fall.
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic d1;
    logic d2;
    int   run;
    int   age;
    logic filt;
    logic press;
    logic rel;
    logic lng;
  } mstate_t;

  localparam mstate_t M_RESET = '{d1: 1'b1, d2: 1'b1, run: 0, age: 0,
                                  filt: 1'b1, press: 1'b0, rel: 1'b0, lng: 1'b0};

  function automatic mstate_t mstep(mstate_t s, logic k);
    mstate_t n;
    n       = s;
    n.d1    = k;
    n.d2    = s.d1;
    n.press = 1'b0;
    n.rel   = 1'b0;
    n.lng   = 1'b0;
    if (!s.filt) begin
      if (s.age <= LONG_CNT) n.age = s.age + 1;
      if (n.age == LONG_CNT) n.lng = 1'b1;
    end
    if (s.d2 != s.filt) begin
      n.run = s.run + 1;
      if (n.run == DEB_CNT + 1) begin
        n.filt = ~s.filt;
        n.run  = 0;
        if (!n.filt) begin
          n.press = 1'b1;
          n.age   = 0;
        end else begin
          n.rel = 1'b1;
        end
      end
    end else begin
      n.run = 0;
    end
    return n;
  endfunction

  mstate_t m = M_RESET;

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) m <= M_RESET;
    else            m <= mstep(m, key);
  end

  logic [3:0] w_dut;
  logic [3:0] w_mdl;
  assign w_dut = {key_filter, key_press, key_release, key_long};
  assign w_mdl = {m.filt, m.press, m.rel, m.lng};

  // --------------------------------------------------------------------------
  // Checking helpers
  // --------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;
  int cnt_p    = 0;
  int cnt_r    = 0;
  int cnt_l    = 0;

  task automatic check4(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b {filter,press,release,long} t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // One cycle: wait for the falling edge, compare against the model and
  // tally pulses.
  task automatic tick();
    @(negedge sys_clk);
    check4("model", w_dut, w_mdl);
    if (key_press   === 1'b1) cnt_p++;
    if (key_release === 1'b1) cnt_r++;
    if (key_long    === 1'b1) cnt_l++;
  endtask

  // Holds reset for two cycles, then releases it just after a falling edge,
  // so the next rising edge is edge 0.
  task automatic do_reset(input logic k);
    sys_rst_n = 1'b0;
    key       = k;
    repeat (2) tick();
    check4("reset_vals", w_dut, 4'b1000);
    sys_rst_n = 1'b1;
    cnt_p = 0;
    cnt_r = 0;
    cnt_l = 0;
  endtask

  typedef struct {
    logic       k;
    int         n;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int total;
    int len;
    logic lvl;

    sys_rst_n = 1'b1;
    key       = 1'b1;
    #1 sys_rst_n = 1'b0;

    // ---- Clean press, long press, then clean release (edges from 0) ----
    tbl[0] = '{k: 1'b0, n: 10, exp: 4'b1000};  // edges 0..9, not yet accepted
    tbl[1] = '{k: 1'b0, n: 1,  exp: 4'b0100};  // edge 10: press
    tbl[2] = '{k: 1'b0, n: 1,  exp: 4'b0000};  // edge 11: pulse gone
    tbl[3] = '{k: 1'b0, n: 30, exp: 4'b0000};  // edges 12..41
    tbl[4] = '{k: 1'b0, n: 1,  exp: 4'b0001};  // edge 42: long press
    tbl[5] = '{k: 1'b0, n: 1,  exp: 4'b0000};  // edge 43
    tbl[6] = '{k: 1'b0, n: 56, exp: 4'b0000};  // edges 44..99
    tbl[7] = '{k: 1'b1, n: 10, exp: 4'b0000};  // edges 100..109
    tbl[8] = '{k: 1'b1, n: 1,  exp: 4'b1010};  // edge 110: release

    do_reset(1'b1);
    for (int i = 0; i < 9; i++) begin
      key = tbl[i].k;
      repeat (tbl[i].n) tick();
      check4($sformatf("tbl[%0d]", i), w_dut, tbl[i].exp);
    end
    check_int("t14_press_cnt", cnt_p, 1);
    check_int("t14_long_cnt",  cnt_l, 1);
    check_int("t14_rel_cnt",   cnt_r, 1);

    // ---- Bounce: 0/1 every 3 cycles, then steady high ----
    do_reset(1'b1);
    for (int i = 0; i < 40; i++) begin
      key = ((i / 3) % 2 == 0) ? 1'b0 : 1'b1;
      tick();
    end
    key = 1'b1;
    repeat (20) tick();
    check4("t2_level", w_dut, 4'b1000);
    check_int("t2_pulses", cnt_p + cnt_r + cnt_l, 0);

    // ---- Release with a 4-cycle high glitch ----
    do_reset(1'b1);
    key = 1'b0;
    repeat (15) tick();
    key = 1'b1;
    repeat (4) tick();
    key = 1'b0;
    repeat (5) tick();
    check_int("t3_glitch_rel", cnt_r, 0);
    key = 1'b1;
    for (int s = 0; s <= 12; s++) begin
      tick();
      if (s == 9)  check4("t3_pre_release", w_dut, 4'b0000);
      if (s == 10) check4("t3_release",     w_dut, 4'b1010);
    end
    check_int("t3_rel_cnt", cnt_r, 1);

    // ---- Short press ----
    do_reset(1'b1);
    key = 1'b0;
    repeat (20) tick();
    key = 1'b1;
    repeat (30) tick();
    check_int("t5_press_cnt", cnt_p, 1);
    check_int("t5_rel_cnt",   cnt_r, 1);
    check_int("t5_long_cnt",  cnt_l, 0);

    // ---- Reset mid-press with key still held ----
    do_reset(1'b1);
    key = 1'b0;
    repeat (15) tick();
    check4("t6_pressed", w_dut, 4'b0000);
    sys_rst_n = 1'b0;
    #1;
    check4("t6_async_rst", w_dut, 4'b1000);
    tick();
    sys_rst_n = 1'b1;
    cnt_p = 0;
    for (int s = 0; s <= 11; s++) begin
      tick();
      if (s == 9)  check4("t6_pre_press", w_dut, 4'b1000);
      if (s == 10) check4("t6_re_press",  w_dut, 4'b0100);
    end
    check_int("t6_press_cnt", cnt_p, 1);

    // ---- Randomised activity against the model ----
    do_reset(1'b1);
    total = 0;
    lvl   = 1'b1;
    while (total < 3000) begin
      lvl = ~lvl;
      key = lvl;
      len = ($urandom_range(0, 9) < 6) ? $urandom_range(1, 12) : $urandom_range(13, 60);
      if ($urandom_range(0, 39) == 0) begin
        sys_rst_n = 1'b0;
        #2 sys_rst_n = 1'b1;
      end
      repeat (len) tick();
      total += len;
    end
    key = 1'b1;
    repeat (DEB_CNT + 4) tick();
    check4("rand_final_level", w_dut, 4'b1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
